// File: rtl/step_trigger_voice.sv
// Drum-hit voice: samples one pattern tap on each step strobe and plays a fixed-length square-wave burst.
// Optional falling-pitch sweep is enabled with the PITCH_SWEEP_EN macro.
module step_trigger_voice #(
    parameter int WIDTH       = 16,
    parameter int TAP         = 0,
    parameter int DIV_WIDTH   = 24,
    parameter int HALF_PERIOD = 13636,
    parameter int BURST_WIDTH = 24,
    parameter int BURST_LEN   = 1200000,
    parameter int SWEEP_STEP  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [WIDTH-1:0] pattern,
    output logic             gate,
    output logic             audio_out,
    output logic             hit
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    localparam logic [DIV_WIDTH-1:0]   PERIOD_INIT = DIV_WIDTH'(HALF_PERIOD);
    localparam logic [BURST_WIDTH-1:0] BURST_LAST  = BURST_WIDTH'(BURST_LEN - 1);

    logic [0:0]             state;
    logic [BURST_WIDTH-1:0] burst_cnt;
    logic [DIV_WIDTH-1:0]   half_cnt;
    logic [DIV_WIDTH-1:0]   period;
    logic                   audio_q;
    logic                   hit_q;

    logic trigger;
    logic burst_done;
    logic half_wrap;

    assign trigger    = step & pattern[TAP];
    assign burst_done = (burst_cnt == BURST_LAST);
    assign half_wrap  = (half_cnt == period - DIV_WIDTH'(1));

`ifdef PITCH_SWEEP_EN
    logic [DIV_WIDTH:0]   period_sum;
    logic [DIV_WIDTH-1:0] period_swept;

    // Carry out of the widened sum means the period would overflow; pin it at all-ones.
    assign period_sum   = {1'b0, period} + (DIV_WIDTH + 1)'(SWEEP_STEP);
    assign period_swept = period_sum[DIV_WIDTH] ? '1 : period_sum[DIV_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period <= PERIOD_INIT;
        end else if (trigger) begin
            period <= PERIOD_INIT;
        end else if (state == ST_PLAY && !burst_done && half_wrap) begin
            period <= period_swept;
        end
    end
`else
    logic [31:0] sweep_step_unused;

    assign period            = PERIOD_INIT;
    assign sweep_step_unused = SWEEP_STEP;
`endif

    // NOTE: every register here updates with <= so all of them see the same pre-edge values of each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
            half_cnt  <= '0;
            audio_q   <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            hit_q <= trigger;
            if (trigger) begin
                // A retrigger always wins, even on the last gate-high cycle, and restarts the phase high.
                state     <= ST_PLAY;
                burst_cnt <= '0;
                half_cnt  <= '0;
                audio_q   <= 1'b1;
            end else if (state == ST_PLAY) begin
                if (burst_done) begin
                    state     <= ST_IDLE;
                    burst_cnt <= '0;
                    half_cnt  <= '0;
                    audio_q   <= 1'b0;
                end else begin
                    burst_cnt <= burst_cnt + BURST_WIDTH'(1);
                    if (half_wrap) begin
                        half_cnt <= '0;
                        audio_q  <= ~audio_q;
                    end else begin
                        half_cnt <= half_cnt + DIV_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign gate      = (state == ST_PLAY);
    assign audio_out = audio_q;
    assign hit       = hit_q;

endmodule

// File: tb/tb_step_trigger_voice.sv
// Bench for step_trigger_voice: directed scenarios plus random steps against a cycles-since-trigger model.
// Build with PITCH_SWEEP_EN defined to exercise the pitch sweep.
module tb_step_trigger_voice;

    localparam int WIDTH = 16;
    localparam int TAP   = 0;
    localparam int HP    = 4;
    localparam int SS    = 1;
    localparam int MAXP  = (1 << 24) - 1;
`ifdef PITCH_SWEEP_EN
    localparam int BL    = 40;
    localparam bit SWEEP = 1'b1;
`else
    localparam int BL    = 20;
    localparam bit SWEEP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             step;
    logic [WIDTH-1:0] pattern;
    logic             gate;
    logic             audio_out;
    logic             hit;

    int n_checks = 0;
    int n_pass   = 0;
    int since    = -1;   // cycles since last trigger edge; -1 when silent

    step_trigger_voice #(
        .WIDTH(WIDTH), .TAP(TAP), .DIV_WIDTH(24), .HALF_PERIOD(HP),
        .BURST_WIDTH(24), .BURST_LEN(BL), .SWEEP_STEP(SS)
    ) dut (
        .clk(clk), .rst(rst), .step(step), .pattern(pattern),
        .gate(gate), .audio_out(audio_out), .hit(hit)
    );

    always #5 clk = ~clk;

    // Audio level e cycles into a burst, walking whole half-periods.
    function automatic logic model_audio(input int e);
        int   p   = HP;
        int   pos = e;
        logic ph  = 1'b1;
        while (pos >= p) begin
            pos -= p;
            ph = ~ph;
            if (SWEEP) p = (p + SS > MAXP) ? MAXP : p + SS;
        end
        return ph;
    endfunction

    function automatic logic [2:0] model_out();
        if (since < 0) return 3'b000;
        return {1'b1, model_audio(since), since == 0};
    endfunction

    task automatic tick(input logic s, input logic [WIDTH-1:0] p);
        step    = s;
        pattern = p;
        @(posedge clk);
        #1;
        if (s && p[TAP]) since = 0;
        else if (since >= 0) begin
            since++;
            if (since >= BL) since = -1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < BL + 3; i++) tick(1'b0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b1; step = 1'b0; pattern = '0;
        #12;
        n_checks++;
        if ({gate, audio_out, hit} !== 3'b000)
            $display("FAIL reset: got %b expected 000", {gate, audio_out, hit});
        else n_pass++;
        @(negedge clk) rst = 1'b0;
        since = -1;
    endtask

    task automatic test_basic_hit(input string name);
        int hits = 0, gates = 0;
        for (int i = 0; i < 3; i++) tick(1'b0, 16'h0001);
        tick(1'b1, 16'h0001);
        for (int i = 0; i < BL + 4; i++) begin
            hits  += hit;
            gates += gate;
            n_checks++;
            if ({gate, audio_out, hit} !== model_out())
                $display("FAIL %s cycle %0d: got %b expected %b", name, i, {gate, audio_out, hit}, model_out());
            else n_pass++;
            tick(1'b0, '0);
        end
        n_checks++;
        if (hits !== 1) $display("FAIL %s_hit_count: got %0d expected 1", name, hits);
        else n_pass++;
        n_checks++;
        if (gates !== BL) $display("FAIL %s_gate_len: got %0d expected %0d", name, gates, BL);
        else n_pass++;
    endtask

    task automatic test_no_trigger();
        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) tick(1'b1, 16'hFFFE);
            else            tick(1'b0, 16'h0001);
            n_checks++;
            if ({gate, audio_out, hit} !== 3'b000)
                $display("FAIL no_trigger cycle %0d: got %b expected 000", i, {gate, audio_out, hit});
            else n_pass++;
        end
    endtask

    task automatic test_retrigger(input string name, input int gap);
        int low_seen = 0;
        tick(1'b1, 16'h0001);
        for (int i = 1; i < gap; i++) tick(1'b0, '0);
        tick(1'b1, 16'h0001);
        for (int i = 0; i < BL + 4; i++) begin
            if (i < BL && !gate) low_seen++;
            n_checks++;
            if ({gate, audio_out, hit} !== model_out())
                $display("FAIL %s cycle %0d: got %b expected %b", name, i, {gate, audio_out, hit}, model_out());
            else n_pass++;
            tick(1'b0, '0);
        end
        n_checks++;
        if (low_seen !== 0) $display("FAIL %s_gate_gap: got %0d low cycles expected 0", name, low_seen);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        tick(1'b1, 16'h0001);
        for (int i = 0; i < 4; i++) tick(1'b0, '0);
        #2 rst = 1'b1;
        #1;
        since = -1;
        n_checks++;
        if ({gate, audio_out, hit} !== 3'b000)
            $display("FAIL async_reset: got %b expected 000", {gate, audio_out, hit});
        else n_pass++;
        @(negedge clk) rst = 1'b0;
        test_basic_hit("after_reset");
    endtask

    task automatic test_tone();
        int runs[4];
        int nrun = 0, run = 1, bound = 0, first = 0;
        logic prev;
        tick(1'b1, 16'h0001);
        prev = audio_out;
        while (nrun < 4 && gate && bound < 100) begin
            tick(1'b0, '0);
            bound++;
            if (audio_out === prev) run++;
            else begin
                runs[nrun] = run;
                nrun++;
                run = 1;
                prev = audio_out;
            end
        end
        n_checks++;
        if (nrun !== 4) $display("FAIL tone_runs: got %0d half-periods expected 4", nrun);
        else n_pass++;
        for (int k = 0; k < nrun; k++) begin
            n_checks++;
            if (runs[k] !== (SWEEP ? HP + k * SS : HP))
                $display("FAIL tone_half_%0d: got %0d expected %0d", k, runs[k], SWEEP ? HP + k * SS : HP);
            else n_pass++;
        end
        tick(1'b1, 16'h0001);
        run = 0;
        while (audio_out === 1'b1 && gate && run < 100) begin
            run++;
            tick(1'b0, '0);
        end
        n_checks++;
        if (run !== HP) $display("FAIL tone_retrigger_half: got %0d expected %0d", run, HP);
        else n_pass++;
    endtask

    task automatic test_random();
        logic             s;
        logic [WIDTH-1:0] p;
        for (int i = 0; i < 800; i++) begin
            s = ($urandom_range(0, 7) == 0);
            p = WIDTH'($urandom);
            tick(s, p);
            n_checks++;
            if ({gate, audio_out, hit} !== model_out())
                $display("FAIL random cycle %0d: got %b expected %b", i, {gate, audio_out, hit}, model_out());
            else n_pass++;
            if ($urandom_range(0, 149) == 0) begin
                #2 rst = 1'b1;
                #1;
                since = -1;
                n_checks++;
                if ({gate, audio_out, hit} !== 3'b000)
                    $display("FAIL random_reset cycle %0d: got %b expected 000", i, {gate, audio_out, hit});
                else n_pass++;
                @(negedge clk) rst = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_hit("basic_hit");
        drain();
        test_no_trigger();
        test_retrigger("retrigger", 10);
        drain();
        test_retrigger("final_cycle_retrigger", BL);
        drain();
        test_async_reset();
        drain();
        test_tone();
        drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/step_trigger_voice.md
Name: step_trigger_voice

Overview:
- Downstream consumer of the looping pattern shift register in the logic-noise sequencer.
- Samples one tap bit of the pattern on each sequencer step strobe.
- When the tapped bit is 1, fires a fixed-length square-wave tone burst (a "drum hit") as a 1-bit audio output, with a gate and a hit pulse for mixers and LEDs.
- Runs on the fast system clock; the step strobe is a one-cycle enable in that domain.

Parameters:
- WIDTH, 16, width of the pattern input bus.
- TAP, 0, index of the pattern bit sampled on each step; legal range 0..WIDTH-1.
- DIV_WIDTH, 24, width of the tone half-period counter and period register.
- HALF_PERIOD, 13636, cycles per audio half-period (440 Hz at 12 MHz); legal range 1..2^DIV_WIDTH-1.
- BURST_WIDTH, 24, width of the burst-length counter.
- BURST_LEN, 1200000, cycles the gate stays high per hit (100 ms at 12 MHz); legal range 1..2^BURST_WIDTH-1.
- SWEEP_STEP, 8, half-period increment per audio toggle; used only with PITCH_SWEEP_EN.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- step  input  1  one-cycle sequencer step strobe, synchronous to clk.
- pattern  input  WIDTH  current contents of the looping pattern register.
- gate  output  1  high while a burst is playing.
- audio_out  output  1  square-wave tone; forced 0 whenever gate is 0.
- hit  output  1  one-cycle pulse marking each burst start or retrigger.

Behaviour:
- Reset (async, any time, including mid-burst): state IDLE; gate=0, audio_out=0, hit=0; all counters 0; period register = HALF_PERIOD.
- Trigger condition: step=1 and pattern[TAP]=1, sampled at edge t.
  - If step=1 and pattern[TAP]=0: no effect in any state.
  - If step=0: pattern is ignored.
- States:
  - IDLE: on trigger go to PLAY.
  - PLAY: on trigger stay in PLAY (retrigger). When the burst counter expires and there is no trigger, go to IDLE.
- On trigger, effective from cycle t+1:
  - gate=1, audio_out=1, hit=1 for exactly one cycle.
  - Burst counter and half-period counter cleared; period register reloaded to HALF_PERIOD.
  - Audio phase always restarts high, in both IDLE and PLAY.
- Burst length: gate is high for exactly BURST_LEN cycles (t+1 .. t+BURST_LEN) and low at t+BURST_LEN+1, unless retriggered.
- Retrigger on the final gate-high cycle: retrigger wins; gate stays high continuously with no low cycle, and a new BURST_LEN window starts.
- Tone: the half-period counter counts 0..period-1 while in PLAY. On reaching period-1 it wraps to 0 and audio_out toggles. Result: audio_out toggles every `period` cycles. HALF_PERIOD=1 toggles every cycle.
- End of burst: audio_out=0 and counters frozen at 0 in IDLE; no partial-cycle glitch on audio_out.
- Latency: trigger to gate/audio/hit is 1 cycle; all outputs are registered.
- Widths: counters compare against parameters zero-extended to their own width; there is no overflow inside legal ranges.

Optional Feature:
- Macro: PITCH_SWEEP_EN.
- Defined:
  - On each audio toggle in PLAY, the period register increases by SWEEP_STEP, saturating at 2^DIV_WIDTH-1. This gives a falling "kick" pitch.
  - The period register reloads to HALF_PERIOD on every trigger.
- Undefined:
  - The period register is a constant HALF_PERIOD.
  - SWEEP_STEP is unused and no sweep adder is synthesized.

Test Plan:
- Basic hit (HALF_PERIOD=4, BURST_LEN=20, TAP=0): pulse step with pattern=16'h0001 at cycle 10 -> hit=1 only at cycle 11; gate=1 cycles 11..30, 0 at 31; audio_out=1 for cycles 11..14, 0 for 15..18, 1 for 19..22, and so on; audio_out=0 from cycle 31.
- No trigger: step pulses with pattern=16'hFFFE, plus pattern=16'h0001 with step=0 -> gate, audio_out and hit stay 0 throughout.
- Retrigger: hit at cycle 10, second valid step at cycle 20 -> hit at 11 and 21; gate continuously high 11..40; audio phase restarts high at 21.
- Final-cycle retrigger: valid step at cycle 30, i.e. gate's last cycle from a cycle-10 hit -> gate never drops; stays high through cycle 50.
- Async reset mid-burst: assert rst between edges at cycle 15 -> gate, audio_out and hit go 0 immediately without a clock edge; after release, a valid step replays the basic-hit timing exactly.
- PITCH_SWEEP_EN (HALF_PERIOD=4, SWEEP_STEP=1, BURST_LEN=40): single hit -> successive audio half-periods of 4, 5, 6, 7 cycles; a retrigger resets the half-period to 4.
